spram_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port RAM (`spram`, 1-cycle registered read, read-before-write) between port A (e.g. CPU) and port B (e.g. video/ULA fetch). Grants at most one access per clock, drives the RAM's command inputs from a registered stage, and returns read data with a per-port valid strobe. Sits between the requesters and the RAM instance at the core top level.

---
 rtl/spram_arb_pkg.sv | 15 +
 rtl/spram_arb_pick.sv | 18 +
 rtl/spram_arbiter.sv | 84 ++++++++
 tb/tb_spram_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/spram_arb_pkg.sv
// spram_arb_pkg: shared types and constants for the single-port RAM arbiter.
// Optional feature macro: SPRAM_ARB_ROUND_ROBIN_EN (round-robin tie break; fixed A priority otherwise).
package spram_arb_pkg;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;
  localparam int READ_LATENCY = 2;
  typedef struct packed {
    logic  valid;
    port_t port;
  } tag_t;
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif
endpackage

// File: rtl/spram_arb_pick.sv
// spram_arb_pick: combinational grant between two requesters; tie policy selected by SPRAM_ARB_ROUND_ROBIN_EN.
module spram_arb_pick
  import spram_arb_pkg::*;
(
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic last_grant_i,
  output logic ack_a_o,
  output logic ack_b_o
);
  logic a_wins_tie;
  assign a_wins_tie = !ROUND_ROBIN || (last_grant_i == PORT_B);
  // A takes the grant when alone or when it wins the tie; B gets whatever A leaves.
  always_comb begin
    ack_a_o = req_a_i && (!req_b_i || a_wins_tie);
    ack_b_o = req_b_i && !ack_a_o;
  end
endmodule

// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one single-port RAM (1-cycle registered read) between ports A and B.
// Optional feature macro: SPRAM_ARB_ROUND_ROBIN_EN (alternating tie break instead of fixed A priority).
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int address_width = 10,
  parameter int data_width    = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_a,
  input  logic                     req_b,
  input  logic                     wren_a,
  input  logic                     wren_b,
  input  logic [address_width-1:0] address_a,
  input  logic [address_width-1:0] address_b,
  input  logic [data_width-1:0]    data_a,
  input  logic [data_width-1:0]    data_b,
  output logic                     ack_a,
  output logic                     ack_b,
  output logic [data_width-1:0]    rdata_a,
  output logic [data_width-1:0]    rdata_b,
  output logic                     rvalid_a,
  output logic                     rvalid_b,
  output logic                     ram_wren,
  output logic [address_width-1:0] ram_address,
  output logic [data_width-1:0]    ram_data,
  input  logic [data_width-1:0]    ram_q
);
  port_t                           last_grant_q, last_grant_d;
  logic                            ram_wren_q, ram_wren_d;
  logic [address_width-1:0]        ram_address_q, ram_address_d;
  logic [data_width-1:0]           ram_data_q, ram_data_d;
  tag_t [READ_LATENCY-1:0]         tag_q, tag_d;
  logic                            accept;
  port_t                           winner;
  logic                            win_wren;

  // Requests are masked during reset so no ack can escape while reset_n is low.
  spram_arb_pick u_pick (
    .req_a_i      (req_a && reset_n),
    .req_b_i      (req_b && reset_n),
    .last_grant_i (last_grant_q),
    .ack_a_o      (ack_a),
    .ack_b_o      (ack_b)
  );

  // Select the winning command and form the next command register and read-tag contents.
  always_comb begin
    accept        = ack_a || ack_b;
    winner        = ack_b ? PORT_B : PORT_A;
    win_wren      = ack_b ? wren_b : wren_a;
    last_grant_d  = accept ? winner : last_grant_q;
    ram_wren_d    = accept && win_wren;
    ram_address_d = accept ? (ack_b ? address_b : address_a) : ram_address_q;
    ram_data_d    = accept ? (ack_b ? data_b : data_a) : ram_data_q;
    tag_d         = {tag_q[READ_LATENCY-2:0], tag_t'{valid: accept && !win_wren, port: winner}};
  end

  // Command register, grant history and read-tag shift register; reset flushes in-flight reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q  <= PORT_B;
      ram_wren_q    <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      tag_q         <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      ram_wren_q    <= ram_wren_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      tag_q         <= tag_d;
    end
  end

  assign ram_wren    = ram_wren_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign rvalid_a    = tag_q[READ_LATENCY-1].valid && (tag_q[READ_LATENCY-1].port == PORT_A);
  assign rvalid_b    = tag_q[READ_LATENCY-1].valid && (tag_q[READ_LATENCY-1].port == PORT_B);
  assign rdata_a     = ram_q;
  assign rdata_b     = ram_q;
endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: directed and random stimulus against a transaction-level scoreboard of the arbiter plus RAM.
module tb_spram_arbiter;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0, wren_a = 1'b0, wren_b = 1'b0;
  logic [9:0] address_a = '0, address_b = '0;
  logic [7:0] data_a = '0, data_b = '0;
  logic       ack_a, ack_b, rvalid_a, rvalid_b, ram_wren;
  logic [7:0] rdata_a, rdata_b, ram_data, ram_q;
  logic [9:0] ram_address;

  logic [7:0] mem [1024];
  logic [7:0] ref_mem [1024];
  typedef struct {
    int       due;
    bit       port;
    logic [7:0] data;
  } rd_t;
  rd_t pend [$];
  bit         ref_last_b = 1'b1;
  bit         ref_wr = 1'b0;
  logic [9:0] ref_addr = '0;
  logic [7:0] ref_data = '0;
  int errors = 0, checks = 0, cyc = 0;

  always #5 clock = ~clock;

  spram_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req_a(req_a), .req_b(req_b), .wren_a(wren_a), .wren_b(wren_b),
    .address_a(address_a), .address_b(address_b), .data_a(data_a), .data_b(data_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .ram_wren(ram_wren), .ram_address(ram_address), .ram_data(ram_data), .ram_q(ram_q)
  );

  // Single-port RAM with registered, read-before-write output.
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of stimulus: drive, check everything visible this cycle, then log the accepted transfer.
  task automatic step(input bit ra, input bit wa, input logic [9:0] aa, input logic [7:0] da,
                      input bit rb, input bit wb, input logic [9:0] ab, input logic [7:0] db);
    bit ea, eb, va, vb, w;
    logic [7:0] d, ed;
    logic [9:0] a;
    rd_t r;
    req_a = ra; wren_a = wa; address_a = aa; data_a = da;
    req_b = rb; wren_b = wb; address_b = ab; data_b = db;
    #1;
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
    ea = ra && (!rb || ref_last_b);
`else
    ea = ra;
`endif
    eb = rb && !ea;
    check("ack_a", ack_a, ea);
    check("ack_b", ack_b, eb);
    check("ram_wren", ram_wren, ref_wr);
    check("ram_address", ram_address, ref_addr);
    check("ram_data", ram_data, ref_data);
    va = 0; vb = 0; ed = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      va = !pend[0].port; vb = pend[0].port; ed = pend[0].data;
      void'(pend.pop_front());
    end
    check("rvalid_a", rvalid_a, va);
    check("rvalid_b", rvalid_b, vb);
    if (va) check("rdata_a", rdata_a, ed);
    if (vb) check("rdata_b", rdata_b, ed);
    ref_wr = 0;
    if (ea || eb) begin
      w = eb ? wb : wa;
      a = eb ? ab : aa;
      d = eb ? db : da;
      if (w) ref_mem[a] = d;
      else begin
        r.due = cyc + 2; r.port = eb; r.data = ref_mem[a];
        pend.push_back(r);
      end
      ref_wr = w; ref_addr = a; ref_data = d; ref_last_b = eb;
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Hold reset with both requests high; nothing may be acknowledged and outputs sit at reset values.
  task automatic do_reset();
    reset_n = 0; req_a = 1; req_b = 1; wren_a = 1; wren_b = 1;
    #1;
    check("rst_ack_a", ack_a, 0);
    check("rst_ack_b", ack_b, 0);
    check("rst_ram_wren", ram_wren, 0);
    check("rst_ram_address", ram_address, 0);
    check("rst_rvalid_a", rvalid_a, 0);
    check("rst_rvalid_b", rvalid_b, 0);
    @(negedge clock);
    cyc++;
    #1;
    check("rst_ack_a_hold", ack_a, 0);
    pend.delete();
    ref_last_b = 1; ref_wr = 0; ref_addr = '0; ref_data = '0;
    reset_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    @(negedge clock);
    do_reset();
    step(1, 0, 10'h001, 8'h00, 1, 0, 10'h002, 8'h00);
    idle(3);
    step(1, 1, 10'h010, 8'h5A, 0, 0, '0, '0);
    step(1, 0, 10'h010, 8'h00, 0, 0, '0, '0);
    idle(3);
    for (int i = 0; i < 6; i++) step(1, 0, 10'h001, 8'h00, 1, 0, 10'h002, 8'h00);
    step(0, 0, 10'h001, 8'h00, 1, 0, 10'h002, 8'h00);
    idle(3);
    step(1, 0, 10'h010, 8'h00, 0, 0, '0, '0);
    do_reset();
    idle(4);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 8'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 8'($urandom));
    idle(4);
    check("drained", pend.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
